// File: rtl/parity_tx_serializer_if.sv
// Word handshake into the parity serializer.
// The master drives the word and mode; the serializer answers with ready.
interface parity_tx_serializer_if #(
    parameter int DATA_W = 4
);
    logic [DATA_W-1:0] in_data;
    logic              in_odd;
    logic              in_valid;
    logic              in_ready;

    modport master (
        output in_data,
        output in_odd,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_odd,
        input  in_valid,
        output in_ready
    );
endinterface

// File: rtl/parity_tx_serializer.sv
// Framed serial transmitter: start, data LSB-first, parity, stop.
// The captured word and its parity are also presented in parallel.
module parity_tx_serializer #(
    parameter int DATA_W     = 4,
    parameter int BIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    parity_tx_serializer_if.slave in_if,
    output logic                  tx,
    output logic                  busy,
    output logic                  frame_done,
    output logic [DATA_W-1:0]     par_data,
    output logic                  par_bit
);
    localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(BIT_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] par_data_q, par_data_d;
    logic              par_bit_q, par_bit_d;
    logic              tx_q, tx_d;
    logic              ready_q, ready_d;
    logic              accept;
    logic              bit_end;

    always_comb begin
        accept     = in_if.in_valid && ready_q;
        bit_end    = (cnt_q == '0);
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        shift_d    = shift_q;
        par_data_d = par_data_q;
        par_bit_d  = par_bit_q;
        tx_d       = tx_q;

        // tx_d is the line level for the cycle after this edge
        unique case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (accept) begin
                    state_d    = START;
                    shift_d    = in_if.in_data;
                    par_data_d = in_if.in_data;
                    par_bit_d  = (^in_if.in_data) ^ in_if.in_odd;
                    cnt_d      = CNT_LOAD;
                    tx_d       = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    idx_d   = '0;
                    cnt_d   = CNT_LOAD;
                    tx_d    = shift_q[0];
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_d = CNT_LOAD;
                    if (idx_q == IDX_LAST) begin
                        state_d = PARITY;
                        tx_d    = par_bit_q;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        shift_d = shift_q >> 1;
                        tx_d    = shift_d[0];
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                    cnt_d   = CNT_LOAD;
                    tx_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            STOP: begin
                tx_d = 1'b1;
                if (bit_end) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase

        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            shift_q    <= '0;
            par_data_q <= '0;
            par_bit_q  <= 1'b0;
            tx_q       <= 1'b1;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            shift_q    <= shift_d;
            par_data_q <= par_data_d;
            par_bit_q  <= par_bit_d;
            tx_q       <= tx_d;
            ready_q    <= ready_d;
        end
    end

    assign in_if.in_ready = ready_q;
    assign tx             = tx_q;
    assign busy           = (state_q != IDLE);
    assign frame_done     = (state_q == STOP) && bit_end;
    assign par_data       = par_data_q;
    assign par_bit        = par_bit_q;
endmodule

// File: tb/tb_parity_tx_serializer.sv
// Bench for parity_tx_serializer: vector table, scoreboard monitor,
// back-to-back, mid-frame reset, 1- and 3-cycle bit builds, loopback.
module tb_parity_tx_serializer;
    localparam int DW = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    int   last_acc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    parity_tx_serializer_if #(.DATA_W(DW)) bus ();
    parity_tx_serializer_if #(.DATA_W(DW)) if1 ();
    parity_tx_serializer_if #(.DATA_W(DW)) if3 ();

    logic          tx, busy, done, pbit;
    logic [DW-1:0] pdata;
    logic          tx1, busy1, done1, pbit1;
    logic [DW-1:0] pdata1;
    logic          tx3, busy3, done3, pbit3;
    logic [DW-1:0] pdata3;

    parity_tx_serializer #(.DATA_W(DW), .BIT_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_if(bus),
        .tx(tx), .busy(busy), .frame_done(done),
        .par_data(pdata), .par_bit(pbit)
    );

    parity_tx_serializer #(.DATA_W(DW), .BIT_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_if(if1),
        .tx(tx1), .busy(busy1), .frame_done(done1),
        .par_data(pdata1), .par_bit(pbit1)
    );

    parity_tx_serializer #(.DATA_W(DW), .BIT_CYCLES(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_if(if3),
        .tx(tx3), .busy(busy3), .frame_done(done3),
        .par_data(pdata3), .par_bit(pbit3)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic          odd;
        logic          par;
    } vec_t;

    typedef struct {
        logic [DW-1:0] data;
        logic          odd;
        logic          par;
        int            acc;
    } exp_t;

    vec_t vecs[6];
    exp_t sbq[$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h at cycle %0d",
                     nm, act, exp, cyc);
        end
    endtask

    function automatic logic par_model(input logic [DW-1:0] d,
                                       input logic odd);
        int c;
        c = 0;
        for (int i = 0; i < DW; i++) c += int'(d[i]);
        return logic'(c % 2) ^ odd;
    endfunction

    // Expected line level per cycle for a 2-cycle-per-bit frame
    function automatic logic [13:0] frame_of(input logic [DW-1:0] d,
                                             input logic p);
        logic [6:0]  b;
        logic [13:0] f;
        b = {1'b1, p, d, 1'b0};
        for (int j = 0; j < 14; j++) f[j] = b[j / 2];
        return f;
    endfunction

    // Scoreboard monitor
    logic [63:0] fb;
    int          n = 0;
    bit          post = 0;

    always @(negedge clk) begin
        exp_t e;
        int   ones;
        if (!rst_n) begin
            sbq.delete();
            n = 0;
            post = 0;
        end else begin
            if (post) begin
                chk("gap_ready", 32'(bus.in_ready), 1);
                chk("gap_busy", 32'(busy), 0);
                chk("gap_tx", 32'(tx), 1);
                post = 0;
            end
            if (busy) begin
                if (n < 64) fb[n] = tx;
                n++;
            end
            if (done) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_done", 32'(done), 0);
                end else begin
                    e = sbq.pop_front();
                    chk("frame_len", n, 14);
                    chk("frame_bits", 32'(fb[13:0]),
                        32'(frame_of(e.data, e.par)));
                    chk("done_cycle", cyc - e.acc + 1, 14);
                    chk("sb_data", 32'(pdata), 32'(e.data));
                    chk("sb_par", 32'(pbit), 32'(e.par));
                    ones = int'(pbit);
                    for (int i = 0; i < DW; i++) ones += int'(pdata[i]);
                    chk("loopback", ones % 2, 32'(e.odd));
                end
                n = 0;
                post = 1;
            end
        end
    end

    task automatic send(input logic [DW-1:0] d, input logic odd,
                        input logic par, input bit hold);
        exp_t e;
        bit   got;
        got = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                bus.in_valid = 1'b1;
                bus.in_data  = d;
                bus.in_odd   = odd;
                e.data = d;
                e.odd  = odd;
                e.par  = par;
                e.acc  = cyc + 1;
                last_acc = e.acc;
                sbq.push_back(e);
                got = 1;
                break;
            end else begin
                bus.in_data = DW'($urandom);
                bus.in_odd  = 1'($urandom);
            end
        end
        if (!got) begin
            chk("send_timeout", 0, 1);
            return;
        end
        @(negedge clk);
        chk("a1_tx", 32'(tx), 0);
        chk("a1_busy", 32'(busy), 1);
        chk("a1_ready", 32'(bus.in_ready), 0);
        chk("a1_data", 32'(pdata), 32'(d));
        chk("a1_par", 32'(pbit), 32'(par));
        if (!hold) bus.in_valid = 1'b0;
        bus.in_data = DW'($urandom);
        bus.in_odd  = 1'($urandom);
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (!busy && sbq.size() == 0) return;
        end
        chk("idle_timeout", 0, 1);
    endtask

    task automatic run_aux(input int bc, input logic [DW-1:0] d,
                           input logic odd, input logic par);
        logic [6:0] b;
        logic       r, t, bz, dn;
        bit         got;
        b = {1'b1, par, d, 1'b0};
        got = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            r = (bc == 1) ? if1.in_ready : if3.in_ready;
            if (r) begin
                got = 1;
                break;
            end
        end
        if (!got) begin
            chk("aux_timeout", 0, 1);
            return;
        end
        if1.in_data = d;
        if1.in_odd  = odd;
        if3.in_data = d;
        if3.in_odd  = odd;
        if (bc == 1) if1.in_valid = 1'b1;
        else if3.in_valid = 1'b1;
        @(negedge clk);
        if1.in_valid = 1'b0;
        if3.in_valid = 1'b0;
        for (int j = 1; j <= 7 * bc; j++) begin
            if (j > 1) @(negedge clk);
            t  = (bc == 1) ? tx1 : tx3;
            bz = (bc == 1) ? busy1 : busy3;
            dn = (bc == 1) ? done1 : done3;
            chk($sformatf("aux%0d_tx%0d", bc, j), 32'(t),
                32'(b[(j - 1) / bc]));
            chk($sformatf("aux%0d_busy%0d", bc, j), 32'(bz), 1);
            chk($sformatf("aux%0d_done%0d", bc, j), 32'(dn),
                32'(j == 7 * bc));
        end
        @(negedge clk);
        bz = (bc == 1) ? busy1 : busy3;
        r  = (bc == 1) ? if1.in_ready : if3.in_ready;
        chk($sformatf("aux%0d_end_busy", bc), 32'(bz), 0);
        chk($sformatf("aux%0d_end_ready", bc), 32'(r), 1);
        chk($sformatf("aux%0d_par", bc),
            32'((bc == 1) ? pbit1 : pbit3), 32'(par));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int a1;
        int a2;
        vecs[0] = '{4'b1011, 1'b0, 1'b1};
        vecs[1] = '{4'b0111, 1'b1, 1'b0};
        vecs[2] = '{4'b0000, 1'b1, 1'b1};
        vecs[3] = '{4'b1111, 1'b0, 1'b0};
        vecs[4] = '{4'b0001, 1'b0, 1'b1};
        vecs[5] = '{4'b1100, 1'b1, 1'b1};

        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_odd   = 1'b0;
        if1.in_valid = 1'b0;
        if1.in_data  = '0;
        if1.in_odd   = 1'b0;
        if3.in_valid = 1'b0;
        if3.in_data  = '0;
        if3.in_odd   = 1'b0;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tx", 32'(tx), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ready", 32'(bus.in_ready), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_pdata", 32'(pdata), 0);
        chk("rst_pbit", 32'(pbit), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_ready", 32'(bus.in_ready), 1);

        for (int i = 0; i < 6; i++) begin
            send(vecs[i].data, vecs[i].odd, vecs[i].par, 0);
            wait_idle();
        end

        send(4'h5, 1'b0, 1'b0, 1);
        a1 = last_acc;
        send(4'hA, 1'b1, 1'b1, 1);
        a2 = last_acc;
        bus.in_valid = 1'b0;
        chk("b2b_period", a2 - a1, 15);
        wait_idle();

        send(4'hC, 1'b0, 1'b0, 0);
        repeat (4) @(negedge clk);
        chk("pre_rst_busy", 32'(busy), 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_tx", 32'(tx), 1);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_pdata", 32'(pdata), 0);
        chk("mid_rst_done", 32'(done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (16) begin
            @(negedge clk);
            chk("post_rst_nodone", 32'(done), 0);
        end
        send(4'b1011, 1'b0, 1'b1, 0);
        wait_idle();

        run_aux(1, 4'b1011, 1'b0, 1'b1);
        run_aux(3, 4'b0110, 1'b1, 1'b1);

        for (int m = 0; m < 2; m++) begin
            for (int w = 0; w < 16; w++) begin
                send(DW'(w), 1'(m), par_model(DW'(w), 1'(m)), 0);
            end
        end
        wait_idle();
        chk("sb_empty", sbq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
